// File: rtl/pse_arbiter.sv
// rtl/pse_arbiter.sv - two-requester round-robin front end for a shared point-sorting engine
// Optional SORT/DRAIN watchdog is compiled in when PSE_ARB_TIMEOUT_EN is defined.
module pse_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [2:0] num0,
  input  logic [2:0] num1,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  output logic [1:0] pop,
  output logic       pse_reset,
  output logic [2:0] pse_point_num,
  output logic [9:0] pse_xin,
  output logic [9:0] pse_yin,
  input  logic       pse_valid,
  input  logic [9:0] pse_xout,
  input  logic [9:0] pse_yout,
  output logic       out_valid,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic       out_tag,
  output logic [1:0] done,
  output logic [1:0] rej,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, RST, LOAD, SORT, DRAIN, FIN} state_t;

  state_t     state;
  logic       g;
  logic       last;
  logic [2:0] n;
  logic [2:0] cnt;
  logic [1:0] rej_q;
  logic       grant_sel;
  logic [2:0] grant_num;
  logic       grant_go;
  logic       grant_ok;
  logic       tmo;

  function automatic logic [1:0] onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    grant_sel = (req == 2'b11) ? ~last : req[1];
    grant_num = grant_sel ? num1 : num0;
  end

  // No grant while a reject is still on the wire, so the requester can drop req first.
  assign grant_go = (req != 2'b00) && (rej_q == 2'b00);
  assign grant_ok = (grant_num >= 3'd3) && (grant_num <= 3'd6);

`ifdef PSE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign tmo = ((state == SORT) || (state == DRAIN)) && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (((state == SORT) || (state == DRAIN)) && !tmo) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  // Watchdog not built; the comparison folds to constant 0.
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      g         <= 1'b0;
      last      <= 1'b1;
      n         <= 3'd0;
      cnt       <= 3'd0;
      rej_q     <= 2'b00;
      done      <= 2'b00;
      pse_reset <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= 10'd0;
      out_y     <= 10'd0;
      out_tag   <= 1'b0;
    end else begin
      rej_q     <= 2'b00;
      done      <= 2'b00;
      pse_reset <= 1'b0;
      out_valid <= 1'b0;
      if (tmo) begin
        state <= IDLE;
        last  <= g;
        cnt   <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_go) begin
              g <= grant_sel;
              n <= grant_num;
              if (grant_ok) begin
                state     <= RST;
                pse_reset <= 1'b1;
              end else begin
                rej_q <= onehot(grant_sel);
                last  <= grant_sel;
              end
            end
          end
          RST: begin
            state <= LOAD;
            cnt   <= 3'd0;
          end
          LOAD: begin
            if (cnt == n - 3'd1) begin
              state <= SORT;
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          SORT: begin
            if (pse_valid) begin
              out_valid <= 1'b1;
              out_x     <= pse_xout;
              out_y     <= pse_yout;
              out_tag   <= g;
              cnt       <= 3'd1;
              state     <= DRAIN;
            end
          end
          DRAIN: begin
            if (pse_valid) begin
              out_valid <= 1'b1;
              out_x     <= pse_xout;
              out_y     <= pse_yout;
              out_tag   <= g;
              if (cnt == n - 3'd1) begin
                state <= FIN;
                done  <= onehot(g);
                cnt   <= 3'd0;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          FIN: begin
            last  <= g;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy          = (state != IDLE);
  assign pse_point_num = busy ? n : 3'd0;
  assign pop           = (state == LOAD) ? onehot(g) : 2'b00;
  assign pse_xin       = (state == LOAD) ? (g ? x1 : x0) : 10'd0;
  assign pse_yin       = (state == LOAD) ? (g ? y1 : y0) : 10'd0;
  assign err           = tmo;
  assign rej           = rej_q | (tmo ? onehot(g) : 2'b00);

endmodule
